// File: rtl/aud_rec_pkg.sv
// Shared widths, address limit and recorder state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package aud_rec_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 20;
   localparam int CNT_W  = 4;

   localparam logic [ADDR_W-1:0] ADDR_MAX = 20'hFFFFF;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      SKIP,
      RECV,
      PAUSE
   } state_t;

endpackage

// File: rtl/aud_rec_deser.sv
// Left-channel deserialiser: LRC fall detect, one skip bit, 16-bit MSB-first shift.
// Latency: done/word combinational on the 16th sampling edge (18th edge after LRC low seen).
// Backpressure: none; abort drops any partial word, go arms fall detection.
module aud_rec_deser
   import aud_rec_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lrc,
   input  logic              data,
   input  logic              go,
   input  logic              abort,
   output logic              sync,
   output logic              done,
   output logic [DATA_W-1:0] word
);

   logic              lrc_d;
   logic              skip;
   logic              recv;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] shift;

   // A fall only arms a capture while the controller is waiting for one.
   assign sync = go && lrc_d && !lrc && !abort;
   assign done = recv && (cnt == 4'd15) && !abort;
   assign word = {shift[DATA_W-2:0], data};

   // Previous LRC level, tracked continuously so the first WAIT cycle can see a fall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lrc_d <= 1'b0;
      else        lrc_d <= lrc;
   end

   // Capture sequencer: skip one bit after the fall, then shift 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skip  <= 1'b0;
         recv  <= 1'b0;
         cnt   <= '0;
         shift <= '0;
      end else if (abort) begin
         skip <= 1'b0;
         recv <= 1'b0;
         cnt  <= '0;
      end else if (sync) begin
         skip <= 1'b1;
      end else if (skip) begin
         skip <= 1'b0;
         recv <= 1'b1;
         cnt  <= '0;
      end else if (recv) begin
         shift <= word;
         cnt   <= cnt + 4'd1;
         if (cnt == 4'd15) recv <= 1'b0;
      end
   end

endmodule

// File: rtl/aud_recorder.sv
// Recorder control: start/pause/stop FSM, SRAM write pointer, sample output register.
// Latency: sample visible 18 BCLK edges after the first edge seeing LRC low; start seen 1 cycle after assertion.
// Backpressure: none; AUD_REC_WRAP_EN wraps the pointer at 20'hFFFFF instead of stopping.
module aud_recorder
   import aud_rec_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_lrc,
   input  logic              i_start,
   input  logic              i_pause,
   input  logic              i_stop,
   input  logic              i_data,
   output logic [ADDR_W-1:0] o_address,
   output logic [DATA_W-1:0] o_data
);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] wr_ptr;
   logic              active;
   logic              abort;
   logic              sync;
   logic              done;
   logic              wr_en;
   logic              clr_ptr;
   logic              stop_full;
   logic [DATA_W-1:0] word;

   assign active = (state == WAIT) || (state == SKIP) || (state == RECV);
   assign abort  = active && (i_stop || i_pause);
   // done already excludes stop/pause, so a command on the last bit drops the word.
   assign wr_en  = (state == RECV) && done;

`ifdef AUD_REC_WRAP_EN
   assign stop_full = 1'b0;
`else
   assign stop_full = (wr_ptr == ADDR_MAX);
`endif

   aud_rec_deser u_deser (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .lrc   (i_lrc),
      .data  (i_data),
      .go    (state == WAIT),
      .abort (abort),
      .sync  (sync),
      .done  (done),
      .word  (word)
   );

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next state: stop beats pause beats start.
   always_comb begin
      state_nxt = state;
      clr_ptr   = 1'b0;
      if (i_stop) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (!i_pause && i_start) begin
                  state_nxt = WAIT;
                  clr_ptr   = 1'b1;
               end
            end
            WAIT: begin
               if (i_pause)   state_nxt = PAUSE;
               else if (sync) state_nxt = SKIP;
            end
            SKIP: begin
               if (i_pause) state_nxt = PAUSE;
               else         state_nxt = RECV;
            end
            RECV: begin
               if (i_pause)   state_nxt = PAUSE;
               else if (done) state_nxt = stop_full ? IDLE : WAIT;
            end
            PAUSE: begin
               if (!i_pause && i_start) state_nxt = WAIT;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Write pointer and published sample; the pointer wraps naturally when wrap is enabled.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr    <= '0;
         o_address <= '0;
         o_data    <= '0;
      end else if (clr_ptr) begin
         wr_ptr <= '0;
      end else if (wr_en) begin
         o_data    <= word;
         o_address <= wr_ptr;
         if (!stop_full) wr_ptr <= wr_ptr + 20'd1;
      end
   end

endmodule

// File: tb/tb_aud_recorder.sv
// Bench for aud_recorder: frame-level reference model feeding a scoreboard queue.
// Latency: monitor compares whenever o_address/o_data change.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_aud_recorder;
   import aud_rec_pkg::*;

   localparam int HALF    = 21;
   localparam int C_NONE  = 0;
   localparam int C_START = 1;
   localparam int C_PAUSE = 2;
   localparam int C_STOP  = 3;

   typedef enum {M_IDLE, M_REC, M_PAUSED} mode_t;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic              lrc   = 1'b1;
   logic              start = 1'b0;
   logic              pause = 1'b0;
   logic              stop  = 1'b0;
   logic              data  = 1'b0;
   logic [ADDR_W-1:0] o_address;
   logic [DATA_W-1:0] o_data;

   mode_t             mode     = M_IDLE;
   logic [ADDR_W-1:0] ptr      = '0;
   logic [35:0]       last_exp = '0;
   logic [35:0]       expq[$];
   int                n_checks = 0;
   int                n_fail   = 0;

   always #5 clk = ~clk;

   aud_recorder dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_lrc     (lrc),
      .i_start   (start),
      .i_pause   (pause),
      .i_stop    (stop),
      .i_data    (data),
      .o_address (o_address),
      .o_data    (o_data)
   );

   task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Recording-mode rules for a command, stated at frame granularity.
   function automatic void model_cmd(input int c);
      case (c)
         C_START: begin
            if (mode == M_IDLE) begin
               mode = M_REC;
               ptr  = '0;
            end else if (mode == M_PAUSED) begin
               mode = M_REC;
            end
         end
         C_PAUSE: if (mode == M_REC) mode = M_PAUSED;
         C_STOP:  mode = M_IDLE;
         default: ;
      endcase
   endfunction

   task automatic drive_cmd(input int c, input bit v);
      start = v && (c == C_START);
      pause = v && (c == C_PAUSE);
      stop  = v && (c == C_STOP);
   endtask

   // One LRC frame: left word (optional command at bit mb), then right half (optional command).
   task automatic do_frame(input logic [15:0] w_in, input int mc, input int mb, input int rc);
      logic [15:0] w;
      logic [15:0] sh;
      bit          rec;
      w   = w_in;
      rec = (mode == M_REC) && (mc != C_PAUSE) && (mc != C_STOP);
      model_cmd(mc);
      if (rec) begin
         if ({ptr, w} == last_exp) w = w ^ 16'h0001;
         last_exp = {ptr, w};
         expq.push_back(last_exp);
         if (ptr == ADDR_MAX) begin
`ifdef AUD_REC_WRAP_EN
            ptr = '0;
`else
            mode = M_IDLE;
`endif
         end else begin
            ptr = ptr + 20'd1;
         end
      end
      sh = w;
      for (int k = 0; k < HALF; k++) begin
         lrc = 1'b0;
         if (k >= 2 && k <= 17) begin
            data = sh[15];
            sh   = sh << 1;
         end else begin
            data = 1'($urandom);
         end
         drive_cmd(mc, (mc != C_NONE) && (k == 2 + mb));
         @(negedge clk);
      end
      drive_cmd(C_NONE, 1'b0);
      model_cmd(rc);
      for (int k = 0; k < HALF; k++) begin
         lrc  = 1'b1;
         data = 1'($urandom);
         drive_cmd(rc, (rc != C_NONE) && (k == 5 || k == 6));
         @(negedge clk);
      end
      drive_cmd(C_NONE, 1'b0);
   endtask

   // Monitor: every visible change of the output pair must match the next expected write.
   initial begin
      logic [35:0] prev;
      logic [35:0] cur;
      logic [35:0] e;
      @(posedge rst_n);
      prev = '0;
      forever begin
         @(negedge clk);
         cur = {o_address, o_data};
         if (cur !== prev) begin
            if (expq.size() == 0) begin
               check("unexpected_update", cur, prev);
            end else begin
               e = expq.pop_front();
               check("sample_address", 36'(cur[35:16]), 36'(e[35:16]));
               check("sample_data",    36'(cur[15:0]),  36'(e[15:0]));
            end
            prev = cur;
         end
      end
   end

   // Stimulus: directed scenarios followed by random frames and commands.
   initial begin
      int mc;
      int rc;
      repeat (3) @(negedge clk);
      check("reset_o_data",    36'(o_data),    36'h0);
      check("reset_o_address", 36'(o_address), 36'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Idle: LRC toggles, nothing is recorded.
      do_frame(16'($urandom), C_NONE, 0, C_NONE);
      do_frame(16'($urandom), C_NONE, 0, C_NONE);
      check("idle_o_data",    36'(o_data),    36'h0);
      check("idle_o_address", 36'(o_address), 36'h0);

      // First capture.
      do_frame(16'($urandom), C_NONE, 0, C_START);
      do_frame(16'h9249, C_NONE, 0, C_STOP);

      // Three consecutive frames from a fresh start.
      do_frame(16'($urandom), C_NONE, 0, C_START);
      do_frame(16'h1234, C_NONE, 0, C_NONE);
      do_frame(16'hABCD, C_NONE, 0, C_NONE);
      do_frame(16'h8001, C_NONE, 0, C_STOP);

      // Pause at bit 8 of the second frame, resume keeps the address.
      do_frame(16'($urandom), C_NONE, 0, C_START);
      do_frame(16'h1111, C_NONE, 0, C_NONE);
      do_frame(16'h7777, C_PAUSE, 8, C_START);
      do_frame(16'h5555, C_NONE, 0, C_NONE);

      // Stop mid-frame, restart from address 0.
      do_frame(16'h3C3C, C_STOP, 5, C_START);
      do_frame(16'hC3C3, C_NONE, 0, C_STOP);

      // Pointer near the top of memory.
      do_frame(16'($urandom), C_NONE, 0, C_START);
      force dut.wr_ptr = 20'hFFFFE;
      @(negedge clk);
      release dut.wr_ptr;
      ptr = 20'hFFFFE;
      do_frame(16'hA5A5, C_NONE, 0, C_NONE);
      do_frame(16'h5A5A, C_NONE, 0, C_NONE);
      do_frame(16'h0F0F, C_NONE, 0, C_NONE);
      do_frame(16'hF0F0, C_NONE, 0, C_NONE);

      // Random commands and data.
      for (int i = 0; i < 40; i++) begin
         mc = ($urandom_range(0, 9) < 8) ? C_NONE : int'($urandom_range(1, 3));
         rc = ($urandom_range(0, 9) < 6) ? C_NONE : int'($urandom_range(1, 3));
         do_frame(16'($urandom), mc, int'($urandom_range(0, 15)), rc);
      end

      repeat (5) @(negedge clk);
      check("pending_expected_writes", 36'(expq.size()), 36'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
